universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter: WIDTH, 8, register length in bits; legal range 2..64.
REQ-002 Parameter: RESET_VALUE, {WIDTH{1'b0}}, register contents after reset.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; one clock, no other reset.
REQ-005 Port: en  input  1  operation enable; 0 = hold everything.
REQ-006 Port: mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port: serial_in_r  input  1  bit entering the MSB on shift right.
REQ-008 Port: serial_in_l  input  1  bit entering the LSB on shift left.
REQ-009 Port: parallel_in  input  WIDTH  load data for mode 11.
REQ-010 Port: parallel_out  output  WIDTH  register contents q.
REQ-011 Port: serial_out_r  output  1  q[0], combinational from q.
REQ-012 Port: serial_out_l  output  1  q[WIDTH-1], combinational from q.
REQ-013 Port: count  output  clog2(WIDTH)  shifts in current word, 0..WIDTH-1.
REQ-014 Port: word_done  output  1  registered one-cycle pulse, WIDTH consecutive same-direction shifts complete.

Function
REQ-015 Shift right (en=1, mode=01): q <= {serial_in_r, q[WIDTH-1:1]}.
REQ-016 Shift left (en=1, mode=10): q <= {q[WIDTH-2:0], serial_in_l}.
REQ-017 Parallel load (en=1, mode=11): q <= parallel_in; count <= 0; last direction unchanged.
REQ-018 Hold (mode=00 or en=0): q, count, last direction unchanged; word_done <= 0.
REQ-019 Internal last_dir register records direction of most recent shift; reset value right.
REQ-020 Shift in same direction as last_dir: count <= count+1, or 0 when count==WIDTH-1.
REQ-021 Shift in opposite direction: count <= 1, last_dir updated, shift itself still performed.
REQ-022 word_done <= 1 exactly in the cycle after a shift that wrapped count from WIDTH-1 to 0; 0 otherwise.
REQ-023 Back-to-back words: continuous same-direction shifting produces word_done every WIDTH cycles with no gap.
REQ-024 Serial latency: bit applied on serial_in_r appears on serial_out_r after exactly WIDTH right shifts; same for left path.
REQ-025 Mode change takes effect on the same clock edge it is sampled; no pipeline between mode and q.
REQ-026 Undefined-free: mode values are exhaustively decoded; no X propagation from unused inputs.

Reset
REQ-027 rst=0 asynchronously forces q=RESET_VALUE, count=0, word_done=0, last_dir=right, independent of clk.
REQ-028 Reset mid-word discards the partial word; first shift after release counts as count=1.
REQ-029 Reset release is synchronous in effect: first state update on first rising edge with rst=1.

Verification (WIDTH=8, RESET_VALUE=0)
REQ-030 Reset: q=8'hA5, assert rst=0 between edges -> parallel_out=8'h00, count=0, word_done=0 immediately, before next edge.
REQ-031 SISO right: shift in 1,0,1,1,0,0,1,0 on serial_in_r -> parallel_out=8'h4D, word_done=1 one cycle after 8th edge, serial_out_r then emits 1,0,1,1,0,0,1,0 on next 8 shifts.
REQ-032 Load + left: load 8'h3C, then 8 left shifts with serial_in_l=1 -> serial_out_l sequence 0,0,1,1,1,1,0,0, final q=8'hFF, word_done pulses once.
REQ-033 Direction change: 5 right shifts, then 1 left shift -> count=1, no word_done; 7 more left shifts -> word_done.
REQ-034 Enable/hold: count=3, hold en=0 for 4 cycles with mode=01 -> q and count frozen; resume 5 shifts -> word_done.
REQ-035 Reset mid-word: count=6, pulse rst low -> count=0, q=8'h00; 8 subsequent shifts required for word_done.

Source files
------------

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - Bidirectional shift register with parallel load and word tracking
module universal_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     serial_in_r,
    input  logic                     serial_in_l,
    input  logic [WIDTH-1:0]         parallel_in,
    output logic [WIDTH-1:0]         parallel_out,
    output logic                     serial_out_r,
    output logic                     serial_out_l,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     word_done
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             word_done_q, word_done_d;
    dir_t             last_dir_q, last_dir_d;
    logic             shift_en;
    dir_t             shift_dir;

    always_comb begin
        q_d         = q_q;
        count_d     = count_q;
        last_dir_d  = last_dir_q;
        word_done_d = 1'b0;
        shift_en    = 1'b0;
        shift_dir   = DIR_RIGHT;

        if (en) begin
            case (mode)
                2'b00: begin
                end
                2'b01: begin
                    q_d       = {serial_in_r, q_q[WIDTH-1:1]};
                    shift_en  = 1'b1;
                    shift_dir = DIR_RIGHT;
                end
                2'b10: begin
                    q_d       = {q_q[WIDTH-2:0], serial_in_l};
                    shift_en  = 1'b1;
                    shift_dir = DIR_LEFT;
                end
                2'b11: begin
                    q_d     = parallel_in;
                    count_d = '0;
                end
            endcase
        end

        // A direction reversal starts a fresh word with the current shift as its first bit
        if (shift_en) begin
            if (shift_dir == last_dir_q) begin
                if (count_q == CNT_MAX) begin
                    count_d     = '0;
                    word_done_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end else begin
                count_d    = CW'(1);
                last_dir_d = shift_dir;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q         <= RESET_VALUE;
            count_q     <= '0;
            word_done_q <= 1'b0;
            last_dir_q  <= DIR_RIGHT;
        end else begin
            q_q         <= q_d;
            count_q     <= count_d;
            word_done_q <= word_done_d;
            last_dir_q  <= last_dir_d;
        end
    end

    assign parallel_out = q_q;
    assign serial_out_r = q_q[0];
    assign serial_out_l = q_q[WIDTH-1];
    assign count        = count_q;
    assign word_done    = word_done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - Directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       serial_in_r;
    logic       serial_in_l;
    logic [7:0] parallel_in;
    logic [7:0] parallel_out;
    logic       serial_out_r;
    logic       serial_out_l;
    logic [2:0] count;
    logic       word_done;

    int tests_run;
    int tests_failed;

    universal_shift_reg #(
        .WIDTH      (8),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .serial_in_r (serial_in_r),
        .serial_in_l (serial_in_l),
        .parallel_in (parallel_in),
        .parallel_out(parallel_out),
        .serial_out_r(serial_out_r),
        .serial_out_l(serial_out_l),
        .count       (count),
        .word_done   (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        en   = 1'b1;
        mode = 2'b00;
    endtask

    task automatic shift_r(input logic b);
        en = 1'b1; mode = 2'b01; serial_in_r = b;
        step();
    endtask

    task automatic shift_l(input logic b);
        en = 1'b1; mode = 2'b10; serial_in_l = b;
        step();
    endtask

    task automatic load(input logic [7:0] d);
        en = 1'b1; mode = 2'b11; parallel_in = d;
        step();
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (parallel_out !== 8'h00 || count !== 3'd0 || word_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_initial: q=%h count=%0d wd=%b, want q=00 count=0 wd=0",
                     parallel_out, count, word_done);
        end
        load(8'hA5);
        tests_run++;
        if (parallel_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL load_a5: q=%h want a5", parallel_out);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (parallel_out !== 8'h00 || count !== 3'd0 || word_done !== 1'b0 ||
            serial_out_r !== 1'b0 || serial_out_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: q=%h count=%0d wd=%b, want q=00 count=0 wd=0",
                     parallel_out, count, word_done);
        end
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_siso_right();
        logic [7:0] bits;
        bits = 8'b0100_1101;
        pulse_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            shift_r(bits[i]);
            tests_run++;
            if (count !== 3'((i + 1) % 8) || word_done !== (i == 7)) begin
                tests_failed++;
                $display("FAIL siso_fill[%0d]: count=%0d wd=%b, want count=%0d wd=%b",
                         i, count, word_done, (i + 1) % 8, (i == 7));
            end
        end
        tests_run++;
        if (parallel_out !== 8'h4D) begin
            tests_failed++;
            $display("FAIL siso_word: q=%h want 4d", parallel_out);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (serial_out_r !== bits[i]) begin
                tests_failed++;
                $display("FAIL siso_out[%0d]: serial_out_r=%b want %b", i, serial_out_r, bits[i]);
            end
            shift_r(1'b0);
            tests_run++;
            if (word_done !== (i == 7)) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: wd=%b want %b", i, word_done, (i == 7));
            end
        end
        tests_run++;
        if (parallel_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL siso_drain: q=%h want 00", parallel_out);
        end
    endtask

    task automatic test_load_left();
        logic [7:0] exp_out;
        exp_out = 8'b0011_1100;
        load(8'h3C);
        tests_run++;
        if (parallel_out !== 8'h3C || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL load_3c: q=%h count=%0d want 3c count=0", parallel_out, count);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (serial_out_l !== exp_out[7 - i]) begin
                tests_failed++;
                $display("FAIL left_out[%0d]: serial_out_l=%b want %b", i, serial_out_l, exp_out[7 - i]);
            end
            shift_l(1'b1);
            tests_run++;
            if (word_done !== (i == 7)) begin
                tests_failed++;
                $display("FAIL left_wd[%0d]: wd=%b want %b", i, word_done, (i == 7));
            end
        end
        tests_run++;
        if (parallel_out !== 8'hFF || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL left_final: q=%h count=%0d want ff count=0", parallel_out, count);
        end
        step();
        tests_run++;
        if (word_done !== 1'b0 || parallel_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL left_pulse_once: wd=%b q=%h want wd=0 q=ff", word_done, parallel_out);
        end
    endtask

    task automatic test_direction_change();
        pulse_reset();
        step();
        for (int i = 0; i < 5; i++) shift_r(1'b1);
        tests_run++;
        if (count !== 3'd5 || parallel_out !== 8'hF8) begin
            tests_failed++;
            $display("FAIL dir_right5: count=%0d q=%h want 5 f8", count, parallel_out);
        end
        shift_l(1'b0);
        tests_run++;
        if (count !== 3'd1 || word_done !== 1'b0 || parallel_out !== 8'hF0) begin
            tests_failed++;
            $display("FAIL dir_flip: count=%0d wd=%b q=%h want 1 0 f0", count, word_done, parallel_out);
        end
        for (int i = 0; i < 7; i++) begin
            shift_l(1'b0);
            tests_run++;
            if (word_done !== (i == 6)) begin
                tests_failed++;
                $display("FAIL dir_left[%0d]: wd=%b want %b", i, word_done, (i == 6));
            end
        end
    endtask

    task automatic test_enable_hold();
        pulse_reset();
        step();
        for (int i = 0; i < 3; i++) shift_r(1'b1);
        for (int i = 0; i < 4; i++) begin
            en = 1'b0; mode = 2'b01; serial_in_r = 1'b0;
            @(posedge clk);
            #1;
            tests_run++;
            if (parallel_out !== 8'hE0 || count !== 3'd3 || word_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_en0[%0d]: q=%h count=%0d wd=%b want e0 3 0",
                         i, parallel_out, count, word_done);
            end
        end
        step();
        tests_run++;
        if (parallel_out !== 8'hE0 || count !== 3'd3) begin
            tests_failed++;
            $display("FAIL hold_mode0: q=%h count=%0d want e0 3", parallel_out, count);
        end
        for (int i = 0; i < 5; i++) begin
            shift_r(1'b0);
            tests_run++;
            if (word_done !== (i == 4)) begin
                tests_failed++;
                $display("FAIL hold_resume[%0d]: wd=%b want %b", i, word_done, (i == 4));
            end
        end
        tests_run++;
        if (parallel_out !== 8'h07) begin
            tests_failed++;
            $display("FAIL hold_final: q=%h want 07", parallel_out);
        end
    endtask

    task automatic test_reset_mid_word();
        pulse_reset();
        step();
        for (int i = 0; i < 6; i++) shift_r(1'b1);
        tests_run++;
        if (count !== 3'd6 || parallel_out !== 8'hFC) begin
            tests_failed++;
            $display("FAIL mid_pre: count=%0d q=%h want 6 fc", count, parallel_out);
        end
        pulse_reset();
        tests_run++;
        if (count !== 3'd0 || parallel_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: count=%0d q=%h want 0 00", count, parallel_out);
        end
        for (int i = 0; i < 8; i++) begin
            shift_r(1'b0);
            tests_run++;
            if (count !== 3'((i + 1) % 8) || word_done !== (i == 7)) begin
                tests_failed++;
                $display("FAIL mid_after[%0d]: count=%0d wd=%b want %0d %b",
                         i, count, word_done, (i + 1) % 8, (i == 7));
            end
        end
    endtask

    task automatic test_left_latency();
        pulse_reset();
        step();
        shift_l(1'b1);
        for (int i = 0; i < 6; i++) shift_l(1'b0);
        tests_run++;
        if (serial_out_l !== 1'b0 || parallel_out !== 8'h40) begin
            tests_failed++;
            $display("FAIL left_lat7: serial_out_l=%b q=%h want 0 40", serial_out_l, parallel_out);
        end
        shift_l(1'b0);
        tests_run++;
        if (serial_out_l !== 1'b1 || parallel_out !== 8'h80) begin
            tests_failed++;
            $display("FAIL left_lat8: serial_out_l=%b q=%h want 1 80", serial_out_l, parallel_out);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        en           = 1'b0;
        mode         = 2'b00;
        serial_in_r  = 1'b0;
        serial_in_l  = 1'b0;
        parallel_in  = 8'h00;
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_siso_right();
        test_load_left();
        test_direction_change();
        test_enable_hold();
        test_reset_mid_word();
        test_left_latency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
